// File: rtl/keypad_pkg.sv
// Shared types, default timing and width helpers for the keypad front end.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } chan_state_t;

  localparam int DEF_N_KEYS     = 10;
  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_RPT_DELAY  = 500;
  localparam int DEF_RPT_PERIOD = 100;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int clog2w(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/keypad_key_chan.sv
// One key channel: 2-flop synchroniser, debouncer and press/auto-repeat FSM.
// pulse is combinational and registered by the parent; deb_next is the debounced level after this edge.
module keypad_key_chan
  import keypad_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int RPT_DELAY  = DEF_RPT_DELAY,
  parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  input  logic rpt_en,
  output logic pulse,
  output logic deb_next
);

  localparam int DEB_W = clog2w(DEB_CYCLES);
  localparam int RPT_W = clog2w(max2(RPT_DELAY, RPT_PERIOD));

  logic             sync1;
  logic             sync;
  logic             deb;
  logic [DEB_W-1:0] deb_cnt;
  logic [DEB_W-1:0] deb_cnt_next;
  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_cnt_next;
  chan_state_t      state;
  chan_state_t      state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync    <= 1'b0;
      deb     <= 1'b0;
      deb_cnt <= '0;
      rpt_cnt <= '0;
      state   <= IDLE;
    end else begin
      sync1   <= key_in;
      sync    <= sync1;
      deb     <= deb_next;
      deb_cnt <= deb_cnt_next;
      rpt_cnt <= rpt_cnt_next;
      state   <= state_next;
    end
  end

  // Any agreeing sample restarts the count, so short glitches never toggle deb.
  always_comb begin
    deb_next     = deb;
    deb_cnt_next = '0;
    if (sync != deb) begin
      if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        deb_next = ~deb;
      end else begin
        deb_cnt_next = deb_cnt + DEB_W'(1);
      end
    end
  end

  // Release is checked against deb_next so a falling edge suppresses a same-cycle repeat.
  always_comb begin
    state_next   = state;
    rpt_cnt_next = rpt_cnt;
    pulse        = 1'b0;
    case (state)
      IDLE: begin
        rpt_cnt_next = '0;
        if (deb) begin
          pulse      = 1'b1;
          state_next = DELAY;
        end
      end
      DELAY: begin
        if (!deb_next) begin
          state_next   = IDLE;
          rpt_cnt_next = '0;
        end else if (!rpt_en) begin
          rpt_cnt_next = '0;
        end else if (rpt_cnt == RPT_W'(RPT_DELAY - 1)) begin
          pulse        = 1'b1;
          rpt_cnt_next = '0;
          state_next   = REPEAT;
        end else begin
          rpt_cnt_next = rpt_cnt + RPT_W'(1);
        end
      end
      REPEAT: begin
        if (!deb_next) begin
          state_next   = IDLE;
          rpt_cnt_next = '0;
        end else if (!rpt_en) begin
          state_next   = DELAY;
          rpt_cnt_next = '0;
        end else if (rpt_cnt == RPT_W'(RPT_PERIOD - 1)) begin
          pulse        = 1'b1;
          rpt_cnt_next = '0;
        end else begin
          rpt_cnt_next = rpt_cnt + RPT_W'(1);
        end
      end
      default: begin
        state_next   = IDLE;
        rpt_cnt_next = '0;
      end
    endcase
  end

endmodule

// File: rtl/keypad_l2p_rpt.sv
// Keypad front end: per-key debounce, press pulse and auto-repeat, plus a
// registered lowest-index key code, valid strobe and any-key-held flag.
module keypad_l2p_rpt
  import keypad_pkg::*;
#(
  parameter int N_KEYS     = DEF_N_KEYS,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int RPT_DELAY  = DEF_RPT_DELAY,
  parameter int RPT_PERIOD = DEF_RPT_PERIOD,
  localparam int CODE_W    = clog2w(N_KEYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] input_key,
  input  logic              rpt_en,
  output logic [N_KEYS-1:0] keypad,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              key_held
);

  logic [N_KEYS-1:0] pulse;
  logic [N_KEYS-1:0] deb_next;
  logic [CODE_W-1:0] code_next;

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
    keypad_key_chan #(
      .DEB_CYCLES(DEB_CYCLES),
      .RPT_DELAY (RPT_DELAY),
      .RPT_PERIOD(RPT_PERIOD)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .key_in  (input_key[gi]),
      .rpt_en  (rpt_en),
      .pulse   (pulse[gi]),
      .deb_next(deb_next[gi])
    );
  end

  // Scan high-to-low so the lowest pulsing index is the last one written.
  always_comb begin
    code_next = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (pulse[i]) code_next = CODE_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keypad    <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
    end else begin
      keypad    <= pulse;
      key_valid <= |pulse;
      key_code  <= code_next;
      key_held  <= |deb_next;
    end
  end

endmodule

// File: tb/tb_keypad_l2p_rpt.sv
// Randomised and directed bench for keypad_l2p_rpt against a sample-window /
// due-time reference model.
module tb_keypad_l2p_rpt;

  localparam int NK  = 10;
  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          rpt_en;
  logic [NK-1:0] input_key;
  logic [NK-1:0] keypad;
  logic          key_valid;
  logic [3:0]    key_code;
  logic          key_held;

  always #5 clk = ~clk;

  keypad_l2p_rpt #(
    .N_KEYS    (NK),
    .DEB_CYCLES(DEB),
    .RPT_DELAY (RD),
    .RPT_PERIOD(RP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .input_key(input_key),
    .rpt_en   (rpt_en),
    .keypad   (keypad),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_held (key_held)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: raw samples per key, debounced level, due edge of next repeat.
  int hist [NK][DEB+2];
  int deb_m [NK];
  int deb_d2 [NK];
  int due [NK];
  int k = 0;
  logic [NK-1:0] exp_pad;
  logic          exp_valid;
  logic [3:0]    exp_code;
  logic          exp_held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, k);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NK; i++) begin
      for (int j = 0; j < DEB + 2; j++) hist[i][j] = 0;
      deb_m[i]  = 0;
      deb_d2[i] = 0;
      due[i]    = 0;
    end
    exp_pad   = '0;
    exp_valid = 1'b0;
    exp_code  = '0;
    exp_held  = 1'b0;
  endtask

  task automatic model_edge();
    int d1;
    bit flip;
    k++;
    exp_pad = '0;
    for (int i = 0; i < NK; i++) begin
      for (int j = DEB + 1; j > 0; j--) hist[i][j] = hist[i][j-1];
      hist[i][0] = int'(input_key[i]);
      d1 = deb_m[i];
      // Level accepted once DEB consecutive synchronised samples disagree with it.
      flip = 1'b1;
      for (int j = 2; j <= DEB + 1; j++) if (hist[i][j] == d1) flip = 1'b0;
      if (flip) deb_m[i] = 1 - d1;
      if (d1 == 1 && deb_d2[i] == 0) begin
        exp_pad[i] = 1'b1;
        due[i]     = k + RD;
      end else if (d1 == 1 && deb_m[i] == 1) begin
        if (!rpt_en) due[i] = k + RD;
        else if (k == due[i]) begin
          exp_pad[i] = 1'b1;
          due[i]     = k + RP;
        end
      end
      deb_d2[i] = d1;
    end
    exp_valid = |exp_pad;
    exp_code  = '0;
    for (int i = NK - 1; i >= 0; i--) if (exp_pad[i]) exp_code = 4'(i);
    exp_held = 1'b0;
    for (int i = 0; i < NK; i++) if (deb_m[i] == 1) exp_held = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    chk("keypad", 32'(keypad), 32'(exp_pad));
    chk("key_valid", 32'(key_valid), 32'(exp_valid));
    chk("key_code", 32'(key_code), 32'(exp_code));
    chk("key_held", 32'(key_held), 32'(exp_held));
  endtask

  initial begin
    int e0, tp, cnt, last, a;
    rst       = 1'b1;
    rpt_en    = 1'b0;
    input_key = NK'($urandom);
    model_reset();

    // Reset with random inputs, then idle.
    for (int c = 0; c < 5; c++) begin
      input_key = NK'($urandom);
      tick();
    end
    input_key = '0;
    rst       = 1'b0;
    for (int c = 0; c < 50; c++) tick();

    // Single press, no repeat.
    input_key[3] = 1'b1;
    e0 = k + 1; tp = -1; cnt = 0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (keypad[3]) begin cnt++; if (tp < 0) tp = k; end
    end
    chk("single_latency", 32'(tp - e0), 32'(DEB + 2));
    chk("single_count", 32'(cnt), 32'd1);
    input_key[3] = 1'b0;
    for (int c = 0; c < 20; c++) tick();

    // Bounce rejection on key 5.
    for (int b = 0; b < 4; b++) begin
      input_key[5] = (b % 2 == 0);
      tick(); tick();
    end
    input_key[5] = 1'b1;
    e0 = k + 1; tp = -1; cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (keypad[5]) begin cnt++; if (tp < 0) tp = k; end
    end
    chk("bounce_latency", 32'(tp - e0), 32'(DEB + 2));
    chk("bounce_count", 32'(cnt), 32'd1);
    input_key[5] = 1'b0;
    for (int c = 0; c < 20; c++) tick();

    // Auto-repeat on key 0; release so debounced fall lands before T+60.
    rpt_en = 1'b1;
    input_key[0] = 1'b1;
    tp = -1; cnt = 0; last = -1;
    for (int c = 0; c < 20 && tp < 0; c++) begin
      tick();
      if (keypad[0]) begin tp = k; cnt = 1; last = 0; end
    end
    chk("rpt_press_seen", 32'(tp >= 0), 32'd1);
    for (int c = 0; c < 53; c++) begin
      tick();
      if (keypad[0]) begin cnt++; last = k - tp; end
    end
    input_key[0] = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (keypad[0]) begin cnt++; last = k - tp; end
    end
    chk("rpt_count", 32'(cnt), 32'd6);
    chk("rpt_last_offset", 32'(last), 32'd52);

    // Simultaneous press of keys 2 and 7.
    rpt_en = 1'b0;
    input_key = NK'(10'h084);
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (keypad == NK'(10'h084) && key_code == 4'd2 && key_valid) cnt++;
    end
    chk("simul_count", 32'(cnt), 32'd1);
    input_key = '0;
    for (int c = 0; c < 20; c++) tick();

    // Asynchronous reset during DELAY on key 1.
    rpt_en = 1'b1;
    input_key[1] = 1'b1;
    for (int c = 0; c < DEB + 8; c++) tick();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("abort_keypad", 32'(keypad), 32'd0);
    chk("abort_held", 32'(key_held), 32'd0);
    chk("abort_valid", 32'(key_valid), 32'd0);
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 40; c++) tick();
    input_key[1] = 1'b0;
    for (int c = 0; c < 20; c++) tick();

    // rpt_en dropped during REPEAT on key 4, then re-raised.
    input_key[4] = 1'b1;
    cnt = 0;
    for (int c = 0; c < 60 && cnt < 2; c++) begin
      tick();
      if (keypad[4]) cnt++;
    end
    chk("drop_first_repeat", 32'(cnt), 32'd2);
    tick(); tick(); tick();
    rpt_en = 1'b0;
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (keypad[4]) cnt++;
    end
    chk("drop_silent", 32'(cnt), 32'd0);
    rpt_en = 1'b1;
    a = k; tp = -1;
    for (int c = 0; c < 40 && tp < 0; c++) begin
      tick();
      if (keypad[4]) tp = k;
    end
    chk("reraise_offset", 32'(tp - a), 32'(RD));
    input_key[4] = 1'b0;
    for (int c = 0; c < 20; c++) tick();

    // Random key activity and rpt_en toggling.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 11) == 0) begin
        a = $urandom_range(0, NK - 1);
        input_key[a] = ~input_key[a];
      end
      if ($urandom_range(0, 99) == 0) rpt_en = ~rpt_en;
      tick();
    end
    input_key = '0;
    for (int c = 0; c < 30; c++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
